// File: rtl/mem_1rw_req_ctrl.sv
// mem_1rw_req_ctrl: write/read request arbiter and read response FIFO for one mem_1rw RAM.
// Optional statistics counters are enabled by defining MEM_1RW_REQ_CTRL_STAT_EN.
module mem_1rw_req_ctrl #(
  parameter int WIDTH_ADDR     = 8,
  parameter int WIDTH_DATA     = 8,
  parameter int RD_LATENCY     = 1,
  parameter int RSP_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef MEM_1RW_REQ_CTRL_STAT_EN
  output logic [15:0]           conflict_cnt,
  output logic [15:0]           credit_stall_cnt,
`endif
  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [WIDTH_ADDR-1:0] wr_addr,
  input  logic [WIDTH_DATA-1:0] wr_data,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [WIDTH_ADDR-1:0] rd_addr,
  output logic                  rd_rsp_valid,
  input  logic                  rd_rsp_ready,
  output logic [WIDTH_DATA-1:0] rd_rsp_data,
  output logic                  mem_wen,
  output logic                  mem_ren,
  output logic [WIDTH_ADDR-1:0] mem_addr,
  output logic [WIDTH_DATA-1:0] mem_din,
  input  logic [WIDTH_DATA-1:0] mem_dout
);

  localparam int PW = $clog2(RSP_FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic                  prio_rd;
  logic [RD_LATENCY-1:0] inflight;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         fifo_cnt;
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [WIDTH_DATA-1:0] fifo_mem [RSP_FIFO_DEPTH];
  logic [WIDTH_ADDR-1:0] addr_q;
  logic [WIDTH_DATA-1:0] din_q;

  logic rd_credit_ok;
  logic wr_gnt;
  logic rd_gnt;
  logic push;
  logic pop;

  assign rd_credit_ok = outstanding < CW'(RSP_FIFO_DEPTH);

  // Grant: a lone stream wins; on contention the priority bit decides,
  // except that a read without credit always yields to the write.
  assign wr_gnt = rst_n & wr_req_valid &
                  (~rd_req_valid | ~rd_credit_ok | ~prio_rd);
  assign rd_gnt = rst_n & rd_req_valid & rd_credit_ok &
                  (~wr_req_valid | prio_rd);

  assign wr_req_ready = wr_gnt;
  assign rd_req_ready = rd_gnt;
  assign mem_wen      = wr_gnt;
  assign mem_ren      = rd_gnt;

  assign push         = inflight[RD_LATENCY-1];
  assign rd_rsp_valid = fifo_cnt != '0;
  assign pop          = rd_rsp_valid & rd_rsp_ready;
  assign rd_rsp_data  = fifo_mem[rptr];

  // RAM address/data mux; holds the last granted values when idle.
  always_comb begin
    mem_addr = addr_q;
    mem_din  = din_q;
    unique case (1'b1)
      wr_gnt: begin
        mem_addr = wr_addr;
        mem_din  = wr_data;
      end
      rd_gnt:  mem_addr = rd_addr;
      default: ;
    endcase
  end

  // Arbitration state, read-valid pipeline, FIFO pointers and credit count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_rd     <= 1'b0;
      inflight    <= '0;
      outstanding <= '0;
      fifo_cnt    <= '0;
      wptr        <= '0;
      rptr        <= '0;
      addr_q      <= '0;
      din_q       <= '0;
    end else begin
      if (wr_req_valid && rd_req_valid && rd_credit_ok)
        prio_rd <= ~prio_rd;
      inflight <= RD_LATENCY'({inflight, rd_gnt});
      if (wr_gnt) begin
        addr_q <= wr_addr;
        din_q  <= wr_data;
      end else if (rd_gnt) begin
        addr_q <= rd_addr;
      end
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
      unique case ({rd_gnt, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
    end
  end

  // Response storage; captures RAM data as the read reaches its latency.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= mem_dout;
  end

`ifdef MEM_1RW_REQ_CTRL_STAT_EN
  // Saturating contention and credit-stall cycle counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt     <= '0;
      credit_stall_cnt <= '0;
    end else begin
      if (wr_req_valid && rd_req_valid && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 1'b1;
      if (rd_req_valid && !rd_credit_ok && credit_stall_cnt != 16'hFFFF)
        credit_stall_cnt <= credit_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_1rw_req_ctrl.sv
// tb_mem_1rw_req_ctrl: scoreboard bench for mem_1rw_req_ctrl.
// Instance 0 uses RD_LATENCY=1, instance 1 uses RD_LATENCY=2.
module tb_mem_1rw_req_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]      wr_v, wr_rdy, rd_v, rd_rdy;
  logic [1:0]      rsp_v, rsp_rdy, m_wen, m_ren;
  logic [1:0][7:0] wr_a, wr_d, rd_a, rsp_d, m_addr, m_din;
  logic [7:0]      dout0, dout1, r1_q;
  logic [7:0]      ram0 [256];
  logic [7:0]      ram1 [256];
  logic [7:0]      sh0 [256];
  logic [7:0]      sh1 [256];
  logic [7:0]      q0 [$];
  logic [7:0]      q1 [$];
  int n_tests = 0;
  int n_fail  = 0;

`ifdef MEM_1RW_REQ_CTRL_STAT_EN
  logic [1:0][15:0] cc, cs;
`endif

  mem_1rw_req_ctrl #(
    .WIDTH_ADDR(8), .WIDTH_DATA(8),
    .RD_LATENCY(1), .RSP_FIFO_DEPTH(4)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n),
`ifdef MEM_1RW_REQ_CTRL_STAT_EN
    .conflict_cnt(cc[0]), .credit_stall_cnt(cs[0]),
`endif
    .wr_req_valid(wr_v[0]), .wr_req_ready(wr_rdy[0]),
    .wr_addr(wr_a[0]), .wr_data(wr_d[0]),
    .rd_req_valid(rd_v[0]), .rd_req_ready(rd_rdy[0]),
    .rd_addr(rd_a[0]),
    .rd_rsp_valid(rsp_v[0]), .rd_rsp_ready(rsp_rdy[0]),
    .rd_rsp_data(rsp_d[0]),
    .mem_wen(m_wen[0]), .mem_ren(m_ren[0]),
    .mem_addr(m_addr[0]), .mem_din(m_din[0]),
    .mem_dout(dout0)
  );

  mem_1rw_req_ctrl #(
    .WIDTH_ADDR(8), .WIDTH_DATA(8),
    .RD_LATENCY(2), .RSP_FIFO_DEPTH(4)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef MEM_1RW_REQ_CTRL_STAT_EN
    .conflict_cnt(cc[1]), .credit_stall_cnt(cs[1]),
`endif
    .wr_req_valid(wr_v[1]), .wr_req_ready(wr_rdy[1]),
    .wr_addr(wr_a[1]), .wr_data(wr_d[1]),
    .rd_req_valid(rd_v[1]), .rd_req_ready(rd_rdy[1]),
    .rd_addr(rd_a[1]),
    .rd_rsp_valid(rsp_v[1]), .rd_rsp_ready(rsp_rdy[1]),
    .rd_rsp_data(rsp_d[1]),
    .mem_wen(m_wen[1]), .mem_ren(m_ren[1]),
    .mem_addr(m_addr[1]), .mem_din(m_din[1]),
    .mem_dout(dout1)
  );

  // RAM model, unregistered output
  always @(posedge clk) begin
    if (m_wen[0]) ram0[m_addr[0]] <= m_din[0];
    if (m_ren[0]) dout0 <= ram0[m_addr[0]];
  end

  // RAM model, registered output
  always @(posedge clk) begin
    if (m_wen[1]) ram1[m_addr[1]] <= m_din[1];
    if (m_ren[1]) r1_q <= ram1[m_addr[1]];
    dout1 <= r1_q;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop expected data whenever a response handshake occurs
  always @(negedge clk) begin
    if (rsp_v[0] && rsp_rdy[0]) begin
      if (q0.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rsp0_unexpected: got %0h expected none", rsp_d[0]);
      end else chk("rsp0_data", 32'(rsp_d[0]), 32'(q0.pop_front()));
    end
    if (rsp_v[1] && rsp_rdy[1]) begin
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rsp1_unexpected: got %0h expected none", rsp_d[1]);
      end else chk("rsp1_data", 32'(rsp_d[1]), 32'(q1.pop_front()));
    end
  end

  // Record accepted requests into the shadow memory / expected queue
  function automatic void book(int i);
    if (!rst_n) return;
    if (i == 0) begin
      if (wr_v[0] && wr_rdy[0]) sh0[wr_a[0]] = wr_d[0];
      if (rd_v[0] && rd_rdy[0]) q0.push_back(sh0[rd_a[0]]);
    end else begin
      if (wr_v[1] && wr_rdy[1]) sh1[wr_a[1]] = wr_d[1];
      if (rd_v[1] && rd_rdy[1]) q1.push_back(sh1[rd_a[1]]);
    end
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_v = '0; rd_v = '0; rsp_rdy = '1;
    rst_n = 1'b0;
    q0.delete(); q1.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic preload(input int i);
    for (int k = 0; k < 16; k++) begin
      next();
      wr_v[i] = 1'b1; wr_a[i] = 8'(k); wr_d[i] = 8'(k);
      @(negedge clk);
      chk("preload_wr_ready", 32'(wr_rdy[i]), 32'd1);
      book(i);
    end
    next();
    wr_v[i] = 1'b0;
  endtask

  task automatic run_reads(input int i, input int base, input int n,
                           input int ncyc, output int acc);
    acc = 0;
    for (int c = 0; c < ncyc; c++) begin
      next();
      rd_v[i] = (acc < n);
      rd_a[i] = 8'(base + acc);
      @(negedge clk);
      book(i);
      if (rd_v[i] && rd_rdy[i]) acc++;
    end
    next();
    rd_v[i] = 1'b0;
  endtask

  task automatic drain(input int i, input int budget);
    int c = 0;
    while (((i == 0) ? q0.size() : q1.size()) != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    #1;
    chk("drain_done", 32'((i == 0) ? q0.size() : q1.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, nr, first, last;
    rst_n = 1'b0;
    wr_v = '0; rd_v = '0; rsp_rdy = '1;
    wr_a = '0; wr_d = '0; rd_a = '0;
    #12;
    wr_v = '1; rd_v = '1;
    #1;
    chk("rst_wr_ready", 32'(wr_rdy), 32'd0);
    chk("rst_rd_ready", 32'(rd_rdy), 32'd0);
    chk("rst_wen", 32'(m_wen), 32'd0);
    chk("rst_ren", 32'(m_ren), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_v), 32'd0);
    wr_v = '0; rd_v = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single write then read, latency 1
    next();
    wr_v[0] = 1'b1; wr_a[0] = 8'h05; wr_d[0] = 8'hA5;
    @(negedge clk);
    chk("t1_c0_wen", 32'(m_wen[0]), 32'd1);
    chk("t1_c0_ren", 32'(m_ren[0]), 32'd0);
    chk("t1_c0_addr", 32'(m_addr[0]), 32'h05);
    chk("t1_c0_din", 32'(m_din[0]), 32'hA5);
    book(0);
    next();
    wr_v[0] = 1'b0; rd_v[0] = 1'b1; rd_a[0] = 8'h05;
    @(negedge clk);
    chk("t1_c1_ren", 32'(m_ren[0]), 32'd1);
    chk("t1_c1_wen", 32'(m_wen[0]), 32'd0);
    chk("t1_c1_addr", 32'(m_addr[0]), 32'h05);
    book(0);
    next();
    rd_v[0] = 1'b0;
    @(negedge clk);
    chk("t1_c2_rsp_valid", 32'(rsp_v[0]), 32'd0);
    chk("t1_c2_addr_hold", 32'(m_addr[0]), 32'h05);
    chk("t1_c2_ren", 32'(m_ren[0]), 32'd0);
    @(negedge clk);
    chk("t1_c3_rsp_valid", 32'(rsp_v[0]), 32'd1);
    chk("t1_c3_rsp_data", 32'(rsp_d[0]), 32'hA5);
    drain(0, 10);

    // concurrent requests alternate W,R,W,R
    do_reset();
    begin
      int w, r;
      w = 0; r = 0;
      for (int c = 0; c < 8; c++) begin
        next();
        wr_v[0] = 1'b1; rd_v[0] = 1'b1;
        wr_a[0] = 8'(8'h40 + w); wr_d[0] = 8'(8'h80 + w);
        rd_a[0] = 8'(8'h40 + r);
        @(negedge clk);
        chk("conc_wen", 32'(m_wen[0]), 32'(c % 2 == 0));
        chk("conc_ren", 32'(m_ren[0]), 32'(c % 2 == 1));
        chk("conc_excl", 32'(m_wen[0] & m_ren[0]), 32'd0);
        book(0);
        if (wr_rdy[0]) w++;
        if (rd_rdy[0]) r++;
      end
      next();
      wr_v[0] = 1'b0; rd_v[0] = 1'b0;
    end
    drain(0, 10);

    // back-pressure, latency 2, depth 4
    do_reset();
    preload(1);
    rsp_rdy[1] = 1'b0;
    run_reads(1, 0, 6, 10, acc);
    chk("bp_accepted", 32'(acc), 32'd4);
    run_reads(1, 4, 2, 3, acc);
    chk("bp_still_blocked", 32'(acc), 32'd0);
    rsp_rdy[1] = 1'b1;
    run_reads(1, 4, 2, 12, acc);
    chk("bp_rest_accepted", 32'(acc), 32'd2);
    drain(1, 20);

    // streaming throughput, latency 1
    preload(0);
    nr = 0; first = -1; last = -1; acc = 0;
    for (int c = 0; c < 24; c++) begin
      next();
      rd_v[0] = (acc < 16);
      rd_a[0] = 8'(acc);
      @(negedge clk);
      if (rd_v[0]) chk("stream_rd_ready", 32'(rd_rdy[0]), 32'd1);
      book(0);
      if (rd_v[0] && rd_rdy[0]) acc++;
      if (rsp_v[0]) begin
        nr++;
        if (first < 0) first = c;
        last = c;
      end
    end
    next();
    rd_v[0] = 1'b0;
    chk("stream_acc", 32'(acc), 32'd16);
    chk("stream_nrsp", 32'(nr), 32'd16);
    chk("stream_first", 32'(first), 32'd2);
    chk("stream_span", 32'(last - first), 32'd15);
    drain(0, 10);

    // reset mid-stream: 1 buffered, 2 in flight (latency 2)
    rsp_rdy[1] = 1'b0;
    run_reads(1, 8, 3, 3, acc);
    chk("mid_acc", 32'(acc), 32'd3);
    #1;
    chk("mid_buffered", 32'(rsp_v[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_async_valid", 32'(rsp_v[1]), 32'd0);
    q1.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_rdy[1] = 1'b1;
    nr = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_v[1]) nr++;
    end
    chk("mid_no_rsp", 32'(nr), 32'd0);
    run_reads(1, 7, 1, 2, acc);
    chk("mid_new_acc", 32'(acc), 32'd1);
    drain(1, 10);

`ifdef MEM_1RW_REQ_CTRL_STAT_EN
    do_reset();
    for (int c = 0; c < 10; c++) begin
      next();
      wr_v[0] = 1'b1; rd_v[0] = 1'b1;
      wr_a[0] = 8'h60; wr_d[0] = 8'(c); rd_a[0] = 8'h61;
      @(negedge clk);
      book(0);
    end
    next();
    wr_v[0] = 1'b0; rd_v[0] = 1'b0;
    @(negedge clk);
    chk("stat_conflict", 32'(cc[0]), 32'd10);
    chk("stat_credit_stall", 32'(cs[0]), 32'd0);
    drain(0, 10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
